uart_word_assembler: RTL and testbench

UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

---
 rtl/comm_pkg.sv | 10 +
 rtl/evt_counter.sv | 39 +++
 rtl/uart_word_assembler.sv | 138 +++++++++++++
 tb/tb_uart_word_assembler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Constants and state encoding shared by the UART receive path blocks.
package comm_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    COLLECT_EMPTY = 2'd0,
    COLLECT       = 2'd1,
    HOLD          = 2'd2
  } asm_state_e;
endpackage

// File: rtl/evt_counter.sv
// Saturating event counter with clear priority; done_out flags the terminal value.
module evt_counter #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 255
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_in,
  input  logic en_in,
  output logic done_out
);
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_s;

  assign done_s = (count_q == WIDTH'(TERMINAL));

  // Next count: clear wins, otherwise advance until the terminal value.
  always_comb begin
    count_d = count_q;
    if (clr_in) begin
      count_d = {WIDTH{1'b0}};
    end else if (en_in && !done_s) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done_out = done_s;
endmodule

// File: rtl/uart_word_assembler.sv
// Packs UART bytes little-endian into BYTE_COUNT-byte words with a valid/ready
// hand-off, dropping bytes while a word is held and discarding stale partial words.
module uart_word_assembler
  import comm_pkg::*;
#(
  parameter int BYTE_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            byte_valid_in,
  input  logic [BYTE_W-1:0]               byte_in,
  output logic [BYTE_W*BYTE_COUNT-1:0]    word_out,
  output logic                            word_valid_out,
  input  logic                            word_ready_in,
  output logic [$clog2(BYTE_COUNT+1)-1:0] byte_count_out,
  output logic                            overflow_out,
  output logic                            timeout_out
);
  localparam int CNT_W  = $clog2(BYTE_COUNT + 1);
  localparam int IDX_W  = $clog2(BYTE_COUNT);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WORD_W = BYTE_W * BYTE_COUNT;

  asm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              tmo_q, tmo_d;
  logic              byte_wr_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic              idle_clr_s, idle_en_s, idle_done_s;

  // Next-state, byte-acceptance and pulse decisions.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    ovf_d     = 1'b0;
    tmo_d     = 1'b0;
    byte_wr_s = 1'b0;
    wr_idx_s  = count_q[IDX_W-1:0];
    case (state_q)
      COLLECT_EMPTY, COLLECT: begin
        if (byte_valid_in) begin
          byte_wr_s = 1'b1;
          if (count_q == CNT_W'(BYTE_COUNT - 1)) begin
            state_d = HOLD;
            count_d = CNT_W'(BYTE_COUNT);
            valid_d = 1'b1;
          end else begin
            state_d = COLLECT;
            count_d = count_q + CNT_W'(1);
          end
        end else if ((state_q == COLLECT) && idle_done_s) begin
          state_d = COLLECT_EMPTY;
          count_d = {CNT_W{1'b0}};
          tmo_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (word_ready_in) begin
          // A byte landing with the handshake starts the next word.
          if (byte_valid_in) begin
            byte_wr_s = 1'b1;
            wr_idx_s  = {IDX_W{1'b0}};
            state_d   = COLLECT;
            count_d   = CNT_W'(1);
          end else begin
            state_d = COLLECT_EMPTY;
            count_d = {CNT_W{1'b0}};
          end
        end else begin
          valid_d = 1'b1;
          ovf_d   = byte_valid_in;
        end
      end
      default: begin
        state_d = COLLECT_EMPTY;
        count_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Byte lane write into the word being assembled.
  always_comb begin
    word_d = word_q;
    for (int k = 0; k < BYTE_COUNT; k++) begin
      if (byte_wr_s && (wr_idx_s == IDX_W'(k))) begin
        word_d[k*BYTE_W +: BYTE_W] = byte_in;
      end else begin
        word_d[k*BYTE_W +: BYTE_W] = word_q[k*BYTE_W +: BYTE_W];
      end
    end
  end

  assign idle_en_s  = (state_q == COLLECT);
  assign idle_clr_s = byte_wr_s | tmo_d | (state_q != COLLECT);

  evt_counter #(
    .WIDTH    (IDLE_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_idle_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr_in   (idle_clr_s),
    .en_in    (idle_en_s),
    .done_out (idle_done_s)
  );

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= COLLECT_EMPTY;
      count_q <= {CNT_W{1'b0}};
      word_q  <= {WORD_W{1'b0}};
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign word_out       = word_q;
  assign word_valid_out = valid_q;
  assign byte_count_out = count_q;
  assign overflow_out   = ovf_q;
  assign timeout_out    = tmo_q;
endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed scenarios plus randomized traffic, checked cycle by cycle against a
// queue-based model of the word assembler.
module tb_uart_word_assembler;
  localparam int BC  = 4;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst, bv, rdy;
  logic [7:0]  b;
  logic [31:0] word;
  logic        valid;
  logic [2:0]  cnt;
  logic        ovf, tmo;

  always #5 clk = ~clk;

  uart_word_assembler #(
    .BYTE_COUNT     (BC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .byte_valid_in  (bv),
    .byte_in        (b),
    .word_out       (word),
    .word_valid_out (valid),
    .word_ready_in  (rdy),
    .byte_count_out (cnt),
    .overflow_out   (ovf),
    .timeout_out    (tmo)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int seen_ovf = 0;
  int seen_tmo = 0;
  int base_ovf, base_tmo, dens;
  bit rr, rv, rk;

  // Reference model: bytes of the partial word, the held word, idle edges.
  logic [7:0]  part[$];
  bit          holding  = 1'b0;
  logic [31:0] held_word = 32'h0;
  int          idle     = 0;
  bit          exp_ovf, exp_tmo, exp_zero;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [7:0] d, input bit k);
    exp_ovf  = 1'b0;
    exp_tmo  = 1'b0;
    exp_zero = r;
    if (r) begin
      part.delete();
      holding = 1'b0;
      idle    = 0;
    end else if (holding) begin
      if (k) begin
        holding = 1'b0;
        if (v) begin
          part.push_back(d);
          idle = 0;
        end
      end else if (v) begin
        exp_ovf = 1'b1;
      end
    end else if (v) begin
      part.push_back(d);
      idle = 0;
      if (part.size() == BC) begin
        for (int i = 0; i < BC; i++) held_word[8*i +: 8] = part[i];
        holding = 1'b1;
        part.delete();
      end
    end else if (part.size() > 0) begin
      idle++;
      if (idle == TMO) begin
        part.delete();
        idle    = 0;
        exp_tmo = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit k);
    rst = r; bv = v; b = d; rdy = k;
    @(posedge clk);
    model_edge(r, v, d, k);
    #1;
    check("valid", 32'(valid), 32'(holding));
    check("count", 32'(cnt), holding ? 32'(BC) : 32'(part.size()));
    check("overflow", 32'(ovf), 32'(exp_ovf));
    check("timeout", 32'(tmo), 32'(exp_tmo));
    if (holding) check("word", word, held_word);
    else if (exp_zero) check("word_reset", word, 32'h0);
    seen_ovf += int'(ovf);
    seen_tmo += int'(tmo);
  endtask

  task automatic send(input logic [7:0] d, input bit k);
    cycle(1'b0, 1'b1, d, k);
  endtask

  task automatic idle_for(input int n, input bit k);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, k);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_word", word, 32'h0);
    check("rst_count", 32'(cnt), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);

    // Normal assembly, bytes 20 cycles apart, ready held high
    send(8'h11, 1'b1); idle_for(19, 1'b1);
    send(8'h22, 1'b1); idle_for(19, 1'b1);
    send(8'h33, 1'b1); idle_for(19, 1'b1);
    send(8'h44, 1'b1);
    check("asm_word", word, 32'h44332211);
    check("asm_valid", 32'(valid), 32'd1);
    idle_for(1, 1'b1);
    check("asm_valid_drop", 32'(valid), 32'd0);
    idle_for(3, 1'b1);

    // Backpressure: fifth byte is dropped
    base_ovf = seen_ovf;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    check("bp_ovf", 32'(ovf), 32'd1);
    idle_for(5, 1'b0);
    check("bp_word_held", word, 32'h44332211);
    check("bp_ovf_pulses", 32'(seen_ovf - base_ovf), 32'd1);
    idle_for(1, 1'b1);
    check("bp_released", 32'(valid), 32'd0);

    // Handshake and byte in the same cycle
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    idle_for(2, 1'b0);
    base_ovf = seen_ovf;
    send(8'hAA, 1'b1);
    check("hs_count", 32'(cnt), 32'd1);
    check("hs_no_ovf", 32'(seen_ovf - base_ovf), 32'd0);
    send(8'hB1, 1'b1); send(8'hB2, 1'b1); send(8'hB3, 1'b1);
    check("hs_next_word", word, 32'hB3B2B1AA);
    idle_for(2, 1'b1);

    // Timeout of a partial word
    base_tmo = seen_tmo;
    send(8'h01, 1'b1); send(8'h02, 1'b1);
    idle_for(TMO - 1, 1'b1);
    check("tmo_not_yet", 32'(tmo), 32'd0);
    check("tmo_count_before", 32'(cnt), 32'd2);
    idle_for(1, 1'b1);
    check("tmo_pulse", 32'(tmo), 32'd1);
    check("tmo_count_after", 32'(cnt), 32'd0);
    idle_for(3, 1'b1);
    check("tmo_pulses", 32'(seen_tmo - base_tmo), 32'd1);
    send(8'hA0, 1'b1); send(8'hA1, 1'b1); send(8'hA2, 1'b1); send(8'hA3, 1'b1);
    check("tmo_next_word", word, 32'hA3A2A1A0);
    idle_for(2, 1'b1);

    // A byte on the timeout cycle wins
    base_tmo = seen_tmo;
    send(8'h07, 1'b1);
    idle_for(TMO - 1, 1'b1);
    send(8'h08, 1'b1);
    check("race_count", 32'(cnt), 32'd2);
    check("race_no_tmo", 32'(seen_tmo - base_tmo), 32'd0);
    idle_for(TMO + 2, 1'b1);

    // Reset mid-word, byte during reset ignored
    send(8'h5A, 1'b1); send(8'h5B, 1'b1);
    cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    check("mrst_word", word, 32'h0);
    check("mrst_count", 32'(cnt), 32'd0);
    check("mrst_flags", {29'h0, valid, ovf, tmo}, 32'h0);
    base_ovf = seen_ovf;
    base_tmo = seen_tmo;
    send(8'hC0, 1'b1); idle_for(1, 1'b1);
    send(8'hC1, 1'b1); idle_for(1, 1'b1);
    send(8'hC2, 1'b1); idle_for(1, 1'b1);
    send(8'hC3, 1'b1);
    check("mrst_next_word", word, 32'hC3C2C1C0);
    idle_for(2, 1'b1);
    check("mrst_no_pulses", 32'((seen_ovf - base_ovf) + (seen_tmo - base_tmo)), 32'd0);

    // Randomized traffic at several byte densities
    for (int ph = 0; ph < 12; ph++) begin
      dens = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 10 : 160);
      for (int i = 0; i < 300; i++) begin
        rr = ($urandom_range(0, 299) == 0);
        rv = ($urandom_range(0, dens - 1) == 0);
        rk = 1'($urandom_range(0, 1));
        cycle(rr, rv, 8'($urandom), rk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
